// File: rtl/line_feeder.sv
// -----------------------------------------------------------------------------
// line_feeder
//
// Upstream stage of the VGA output block. Buffers the renderer's pixel stream
// in a small FIFO and, once per display line (started by a rising edge of the
// VGA line-end signal), writes exactly LINE_WIDTH pixels into the VGA line
// buffer through its x / data / active-low program write port.
//
// Short lines (s_last early) are padded with zero pixels; long lines are
// truncated and the surplus input is drained up to the next s_last.
//
// Optional feature: define LINE_FEEDER_PATTERN_EN to add the pattern_in port.
// When it is sampled high at line start, that line is written with colour
// bars instead of FIFO data.
//
// Ports:
//   CLK          system clock (100 MHz)
//   RST          synchronous reset, active low
//   LINEEND_IN   VGA line-end level; its rising edge starts a line fill
//   pattern_in   (LINE_FEEDER_PATTERN_EN only) colour-bar request
//   s_valid/s_data/s_last/s_ready   pixel stream input, valid/ready
//   program_out  line-buffer write strobe, low = write this cycle
//   x_out        line-buffer write address
//   y_out        index of the current or most recent line fill
//   data_out     line-buffer write data
//   err_out      sticky errors: bit0 underrun / late line, bit1 framing
// -----------------------------------------------------------------------------
module line_feeder #(
    parameter int LINE_WIDTH = 1024,
    parameter int LINE_COUNT = 768,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LINEEND_IN,
`ifdef LINE_FEEDER_PATTERN_EN
    input  logic                  pattern_in,
`endif
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  program_out,
    output logic [10:0]           x_out,
    output logic [11:0]           y_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            err_out
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [10:0] X_LAST    = 11'(LINE_WIDTH - 1);
    localparam logic [11:0] Y_LAST    = 12'(LINE_COUNT - 1);

    typedef enum logic [1:0] {S_WAIT, S_FILL, S_PAD, S_DRAIN} state_t;

    // FIFO storage: each entry is {last, pixel}
    logic [DATA_WIDTH:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                s_ready_q, s_ready_d;

    logic                lineend_q, lineend_d;
    logic                lineend_prev_q, lineend_prev_d;

    state_t              state_q, state_d;
    logic [10:0]         x_cnt_q, x_cnt_d;
    logic                program_q, program_d;
    logic [10:0]         x_q, x_d;
    logic [11:0]         y_q, y_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]          err_q, err_d;

    logic                push, pop, fifo_empty, rise;
    logic [DATA_WIDTH:0] head;
    logic [11:0]         y_next;

    // Fill source: FIFO head or, when enabled, the colour-bar generator
    logic                  use_pattern;
    logic [DATA_WIDTH-1:0] pattern_data;
    logic                  src_valid, src_last;
    logic [DATA_WIDTH-1:0] src_data;

`ifdef LINE_FEEDER_PATTERN_EN
    logic       pattern_q, pattern_d;
    logic [2:0] bar;
    assign bar          = x_cnt_q[9:7];
    assign use_pattern  = pattern_q;
    assign pattern_data = DATA_WIDTH'({{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}});
`else
    assign use_pattern  = 1'b0;
    assign pattern_data = '0;
`endif

    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign push       = s_valid & s_ready_q;
    // Registered line-end plus its previous value gives a one-cycle rise pulse
    assign rise       = lineend_q & ~lineend_prev_q;
    assign y_next     = (y_q == Y_LAST) ? 12'd0 : y_q + 12'd1;

    assign src_valid = use_pattern | ~fifo_empty;
    assign src_data  = use_pattern ? pattern_data : head[DATA_WIDTH-1:0];
    assign src_last  = use_pattern ? (x_cnt_q == X_LAST) : head[DATA_WIDTH];

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // can leave it unassigned and infer a latch.
        state_d        = state_q;
        x_cnt_d        = x_cnt_q;
        program_d      = 1'b1;
        x_d            = x_q;
        y_d            = y_q;
        data_d         = data_q;
        err_d          = err_q;
        pop            = 1'b0;
        lineend_d      = LINEEND_IN;
        lineend_prev_d = lineend_q;
`ifdef LINE_FEEDER_PATTERN_EN
        pattern_d      = pattern_q;
`endif

        case (state_q)
            S_WAIT: begin
                if (rise) begin
                    state_d = S_FILL;
                    x_cnt_d = 11'd0;
`ifdef LINE_FEEDER_PATTERN_EN
                    pattern_d = pattern_in;
`endif
                end
            end

            S_FILL: begin
                if (src_valid) begin
                    pop       = ~use_pattern;
                    program_d = 1'b0;
                    x_d       = x_cnt_q;
                    data_d    = src_data;
                    if (x_cnt_q == X_LAST) begin
                        if (src_last) begin
                            state_d = S_WAIT;
                            y_d     = y_next;
                        end else begin
                            // Line too long: discard the rest of it
                            state_d  = S_DRAIN;
                            err_d[1] = 1'b1;
                        end
                    end else begin
                        x_cnt_d = x_cnt_q + 11'd1;
                        if (src_last) begin
                            // Line too short: finish it with zero pixels
                            state_d  = S_PAD;
                            err_d[1] = 1'b1;
                        end
                    end
                end else begin
                    err_d[0] = 1'b1;
                end
            end

            S_PAD: begin
                program_d = 1'b0;
                x_d       = x_cnt_q;
                data_d    = '0;
                if (x_cnt_q == X_LAST) begin
                    state_d = S_WAIT;
                    y_d     = y_next;
                end else begin
                    x_cnt_d = x_cnt_q + 11'd1;
                end
            end

            S_DRAIN: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head[DATA_WIDTH]) begin
                        state_d = S_WAIT;
                        y_d     = y_next;
                    end
                end
            end

            default: state_d = S_WAIT;
        endcase

        // A line start arriving before the previous fill finished is late
        if (rise && (state_q != S_WAIT)) begin
            err_d[0] = 1'b1;
        end

        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
        s_ready_d = (count_d != FIFO_FULL);
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!RST) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            s_ready_q      <= 1'b0;
            lineend_q      <= 1'b0;
            lineend_prev_q <= 1'b0;
            state_q        <= S_WAIT;
            x_cnt_q        <= '0;
            program_q      <= 1'b1;
            x_q            <= '0;
            y_q            <= '0;
            data_q         <= '0;
            err_q          <= '0;
`ifdef LINE_FEEDER_PATTERN_EN
            pattern_q      <= 1'b0;
`endif
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            s_ready_q      <= s_ready_d;
            lineend_q      <= lineend_d;
            lineend_prev_q <= lineend_prev_d;
            state_q        <= state_d;
            x_cnt_q        <= x_cnt_d;
            program_q      <= program_d;
            x_q            <= x_d;
            y_q            <= y_d;
            data_q         <= data_d;
            err_q          <= err_d;
`ifdef LINE_FEEDER_PATTERN_EN
            pattern_q      <= pattern_d;
`endif
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so clearing the contents would be wasted logic.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {s_last, s_data};
        end
    end

    assign s_ready     = s_ready_q;
    assign program_out = program_q;
    assign x_out       = x_q;
    assign y_out       = y_q;
    assign data_out    = data_q;
    assign err_out     = err_q;

endmodule
